// File: rtl/acc_adder_tree_if.sv
// Beat/result bundle for acc_adder_tree: lanes and group sideband in, reduced result out.
interface acc_adder_tree_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                             in_valid;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
  logic                             in_acc;
  logic                             in_last;
  logic                             out_valid;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [CNT_WIDTH-1:0]             out_count;
  logic                             out_sat;

  modport master (
    output in_valid, in_data, in_acc, in_last,
    input  out_valid, out_data, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_acc, in_last,
    output out_valid, out_data, out_count, out_sat
  );
endinterface

// File: rtl/acc_adder_tree.sv
// Pipelined signed adder tree (one register stage per level) followed by a group accumulator.
module acc_adder_tree #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_INPUTS = 8,
  parameter bit          SATURATE   = 1'b1,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input logic             clk,
  input logic             reset_n,
  acc_adder_tree_if.slave bus
);
  localparam int unsigned LEVELS = $clog2(NUM_INPUTS);
  localparam int unsigned NODES  = NUM_INPUTS - 1;
  localparam int unsigned DW     = DATA_WIDTH;
  localparam logic [DW-1:0]        MaxPos = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]        MaxNeg = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  // Returns {overflow_flag, result}; flag only ever set when saturating.
  function automatic logic [DW:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] s;
    logic          ovf;
    s   = a + b;
    ovf = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
    if (SATURATE && ovf) return {1'b1, (a[DW-1] ? MaxNeg : MaxPos)};
    return {1'b0, s};
  endfunction

  // Level k partials sit at r_node[lvl_base(k) +: NUM_INPUTS >> (k+1)]; w_src prepends the lanes.
  function automatic int unsigned lvl_base(input int unsigned k);
    return NUM_INPUTS - (NUM_INPUTS >> k);
  endfunction

  function automatic int unsigned src_base(input int unsigned k);
    return 2 * NUM_INPUTS - ((2 * NUM_INPUTS) >> k);
  endfunction

  logic [DW-1:0]     r_node [NODES];
  logic [DW-1:0]     w_node_d [NODES];
  logic [DW-1:0]     w_src [2*NUM_INPUTS-1];
  logic [DW:0]       w_sum;
  logic [LEVELS-1:0] r_vld, r_acc, r_last, r_bsat;
  logic [LEVELS-1:0] w_vld_in, w_acc_in, w_last_in, w_bsat_in, w_lvl_ovf;

  always_comb begin
    w_vld_in     = '0;
    w_acc_in     = '0;
    w_last_in    = '0;
    w_vld_in[0]  = bus.in_valid;
    w_acc_in[0]  = bus.in_acc;
    w_last_in[0] = bus.in_last;
    for (int unsigned k = 1; k < LEVELS; k++) begin
      w_vld_in[k]  = r_vld[k-1];
      w_acc_in[k]  = r_acc[k-1];
      w_last_in[k] = r_last[k-1];
    end
  end

  always_comb begin
    w_sum     = '0;
    w_node_d  = r_node;
    w_lvl_ovf = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) w_src[i] = bus.in_data[i*DW +: DW];
    for (int unsigned i = 0; i < NODES; i++) w_src[NUM_INPUTS+i] = r_node[i];
    for (int unsigned k = 0; k < LEVELS; k++) begin
      for (int unsigned j = 0; j < NUM_INPUTS / 2; j++) begin
        if (j < (NUM_INPUTS >> (k + 1))) begin
          w_sum        = sat_add(w_src[src_base(k) + 2*j], w_src[src_base(k) + 2*j + 1]);
          w_lvl_ovf[k] = w_lvl_ovf[k] | w_sum[DW];
          if (w_vld_in[k]) w_node_d[lvl_base(k) + j] = w_sum[DW-1:0];
        end
      end
    end
  end

  always_comb begin
    w_bsat_in    = '0;
    w_bsat_in[0] = w_lvl_ovf[0];
    for (int unsigned k = 1; k < LEVELS; k++) w_bsat_in[k] = w_lvl_ovf[k] | r_bsat[k-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NODES; i++) r_node[i] <= '0;
      r_vld  <= '0;
      r_acc  <= '0;
      r_last <= '0;
      r_bsat <= '0;
    end else begin
      r_node <= w_node_d;
      r_vld  <= w_vld_in;
      for (int unsigned k = 0; k < LEVELS; k++) begin
        if (w_vld_in[k]) begin
          r_acc[k]  <= w_acc_in[k];
          r_last[k] <= w_last_in[k];
          r_bsat[k] <= w_bsat_in[k];
        end
      end
    end
  end

  // Accumulator stage
  logic                 r_open, w_open_d;
  logic [DW-1:0]        r_acc_val, w_acc_val_d, w_g_acc;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_d, w_g_cnt;
  logic                 r_gsat, w_gsat_d, w_g_sat;
  logic                 r_out_valid, w_out_valid_d;
  logic [DW-1:0]        r_out_data, w_out_data_d;
  logic [CNT_WIDTH-1:0] r_out_count, w_out_count_d;
  logic                 r_out_sat, w_out_sat_d;
  logic [DW:0]          w_acc_add;
  logic [DW-1:0]        w_tree_sum;
  logic                 w_tree_vld, w_tree_acc, w_tree_last, w_tree_sat;

  assign w_tree_sum  = r_node[NODES-1];
  assign w_tree_vld  = r_vld[LEVELS-1];
  assign w_tree_acc  = r_acc[LEVELS-1];
  assign w_tree_last = r_last[LEVELS-1];
  assign w_tree_sat  = r_bsat[LEVELS-1];
  assign w_acc_add   = sat_add(r_acc_val, w_tree_sum);

  always_comb begin
    w_open_d      = r_open;
    w_acc_val_d   = r_acc_val;
    w_cnt_d       = r_cnt;
    w_gsat_d      = r_gsat;
    w_out_valid_d = 1'b0;
    w_out_data_d  = r_out_data;
    w_out_count_d = r_out_count;
    w_out_sat_d   = r_out_sat;
    if (r_open) begin
      w_g_acc = w_acc_add[DW-1:0];
      w_g_cnt = (r_cnt == CntMax) ? r_cnt : r_cnt + CntOne;
      w_g_sat = r_gsat | w_tree_sat | w_acc_add[DW];
    end else begin
      w_g_acc = w_tree_sum;
      w_g_cnt = CntOne;
      w_g_sat = w_tree_sat;
    end
    if (w_tree_vld) begin
      if (!w_tree_acc) begin
        w_out_valid_d = 1'b1;
        w_out_data_d  = w_tree_sum;
        w_out_count_d = CntOne;
        w_out_sat_d   = w_tree_sat;
      end else if (w_tree_last) begin
        w_out_valid_d = 1'b1;
        w_out_data_d  = w_g_acc;
        w_out_count_d = w_g_cnt;
        w_out_sat_d   = w_g_sat;
        w_open_d      = 1'b0;
      end else begin
        w_open_d    = 1'b1;
        w_acc_val_d = w_g_acc;
        w_cnt_d     = w_g_cnt;
        w_gsat_d    = w_g_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_open      <= 1'b0;
      r_acc_val   <= '0;
      r_cnt       <= '0;
      r_gsat      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_open      <= w_open_d;
      r_acc_val   <= w_acc_val_d;
      r_cnt       <= w_cnt_d;
      r_gsat      <= w_gsat_d;
      r_out_valid <= w_out_valid_d;
      r_out_data  <= w_out_data_d;
      r_out_count <= w_out_count_d;
      r_out_sat   <= w_out_sat_d;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;
  assign bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_acc_adder_tree.sv
// Drives a saturating and a wrapping acc_adder_tree with identical beats; checks both each cycle.
module tb_acc_adder_tree;
  localparam int DW   = 16;
  localparam int N    = 8;
  localparam int CW   = 8;
  localparam int LAT  = 3;
  localparam int MAXP = 32767;
  localparam int MINN = -32768;
  localparam int CMAX = 255;

  typedef struct {
    bit v;
    int d;
    int c;
    bit s;
  } res_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  bit st_valid, st_acc, st_last;
  int st_lane[N];
  int lb[N];

  always #5 clk = ~clk;

  acc_adder_tree_if #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .CNT_WIDTH(CW)) if_s ();
  acc_adder_tree_if #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .CNT_WIDTH(CW)) if_w ();

  acc_adder_tree #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .SATURATE(1'b1), .CNT_WIDTH(CW)) dut_s (
    .clk(clk), .reset_n(reset_n), .bus(if_s.slave)
  );
  acc_adder_tree #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .SATURATE(1'b0), .CNT_WIDTH(CW)) dut_w (
    .clk(clk), .reset_n(reset_n), .bus(if_w.slave)
  );

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, got, got, exp, exp,
               $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int add_v(input int a, input int b, input bit sm);
    int s;
    logic signed [15:0] t;
    s = a + b;
    if (sm) begin
      if (s > MAXP) return MAXP;
      if (s < MINN) return MINN;
      return s;
    end
    t = 16'(s);
    return int'(t);
  endfunction

  function automatic bit add_o(input int a, input int b, input bit sm);
    return sm && ((a + b) > MAXP || (a + b) < MINN);
  endfunction

  function automatic int tree_sum(input int lanes[N], input bit sm, output bit sat);
    int v[N];
    int n;
    v = lanes;
    sat = 1'b0;
    n = N;
    while (n > 1) begin
      for (int j = 0; j < n / 2; j++) begin
        sat  = sat | add_o(v[2*j], v[2*j+1], sm);
        v[j] = add_v(v[2*j], v[2*j+1], sm);
      end
      n = n / 2;
    end
    return v[0];
  endfunction

  bit   m_open[2];
  int   m_acc[2];
  int   m_cnt[2];
  bit   m_gsat[2];
  res_t q[2][$];
  res_t e[2];

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      m_open[m] = 0;
      m_acc[m]  = 0;
      m_cnt[m]  = 0;
      m_gsat[m] = 0;
      q[m].delete();
      for (int i = 0; i < LAT; i++) q[m].push_back('{0, 0, 0, 0});
      e[m] = '{0, 0, 0, 0};
    end
  endtask

  task automatic model_step();
    res_t r, o;
    bit   bs, sm;
    int   s, a, c;
    bit   g;
    for (int m = 0; m < 2; m++) begin
      sm = (m == 0);
      r  = '{0, 0, 0, 0};
      if (st_valid) begin
        s = tree_sum(st_lane, sm, bs);
        if (!st_acc) begin
          r = '{1, s, 1, bs};
        end else begin
          if (!m_open[m]) begin
            a = s; c = 1; g = bs;
          end else begin
            a = add_v(m_acc[m], s, sm);
            c = (m_cnt[m] >= CMAX) ? CMAX : m_cnt[m] + 1;
            g = m_gsat[m] | bs | add_o(m_acc[m], s, sm);
          end
          if (st_last) begin
            r = '{1, a, c, g};
            m_open[m] = 0;
          end else begin
            m_open[m] = 1; m_acc[m] = a; m_cnt[m] = c; m_gsat[m] = g;
          end
        end
      end
      q[m].push_back(r);
      o = q[m].pop_front();
      if (o.v) e[m] = o;
      else e[m].v = 0;
    end
  endtask

  // Compare process: expectations reflect the state after the previous rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) model_clear();
      check("sat valid", int'(if_s.out_valid), int'(e[0].v));
      check("sat data", int'(if_s.out_data), e[0].d & 32'hFFFF);
      check("sat count", int'(if_s.out_count), e[0].c);
      check("sat flag", int'(if_s.out_sat), int'(e[0].s));
      check("wrap valid", int'(if_w.out_valid), int'(e[1].v));
      check("wrap data", int'(if_w.out_data), e[1].d & 32'hFFFF);
      check("wrap count", int'(if_w.out_count), e[1].c);
      check("wrap flag", int'(if_w.out_sat), int'(e[1].s));
      if (reset_n) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input bit v, input bit a, input bit l);
    logic [N*DW-1:0] vec;
    st_valid = v;
    st_acc   = a;
    st_last  = l;
    st_lane  = lb;
    for (int i = 0; i < N; i++) vec[i*DW +: DW] = DW'(lb[i]);
    if_s.in_valid = v; if_s.in_acc = a; if_s.in_last = l; if_s.in_data = vec;
    if_w.in_valid = v; if_w.in_acc = a; if_w.in_last = l; if_w.in_data = vec;
  endtask

  task automatic drive(input bit v, input bit a, input bit l);
    @(posedge clk);
    #1;
    apply(v, a, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  task automatic fill(input int val);
    for (int i = 0; i < N; i++) lb[i] = val;
  endtask

  function automatic int rnd_lane(input bit big);
    logic signed [15:0] t;
    if (big) t = 16'($urandom);
    else t = 16'($urandom_range(0, 200)) - 16'd100;
    return int'(t);
  endfunction

  task automatic rnd_fill();
    bit big;
    big = ($urandom_range(0, 1) == 1);
    for (int i = 0; i < N; i++) lb[i] = rnd_lane(big);
  endtask

  task automatic lit(input string nm, input int d, input int c, input int s);
    check({nm, " valid"}, int'(if_s.out_valid), 1);
    check({nm, " data"}, int'(if_s.out_data), d);
    check({nm, " count"}, int'(if_s.out_count), c);
    check({nm, " flag"}, int'(if_s.out_sat), s);
  endtask

  initial begin
    fill(0);
    apply(0, 0, 0);
    @(negedge clk);
    check("reset valid", int'(if_s.out_valid), 0);
    check("reset data", int'(if_s.out_data), 0);
    check("reset count", int'(if_s.out_count), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Standalone beat of ones
    fill(1);
    drive(1, 0, 0);
    idle(4);
    @(negedge clk);
    lit("ones", 8, 1, 0);
    idle(1);
    @(negedge clk);
    check("ones pulse end", int'(if_s.out_valid), 0);
    check("ones hold", int'(if_s.out_data), 8);

    // Three-beat group of 0..7
    for (int i = 0; i < N; i++) lb[i] = i;
    drive(1, 1, 0);
    drive(1, 1, 0);
    drive(1, 1, 1);
    idle(4);
    @(negedge clk);
    lit("group3", 84, 3, 0);

    // All -1
    fill(-1);
    drive(1, 0, 0);
    idle(4);
    @(negedge clk);
    lit("neg", 'hFFF8, 1, 0);
    check("neg wrap data", int'(if_w.out_data), 'hFFF8);

    // Overflowing lanes
    fill('h7000);
    drive(1, 0, 0);
    idle(4);
    @(negedge clk);
    lit("sat", 'h7FFF, 1, 1);
    check("wrap ovf data", int'(if_w.out_data), 'h8000);
    check("wrap ovf flag", int'(if_w.out_sat), 0);

    // Back-to-back: 1-beat groups alternating with standalone beats
    for (int i = 0; i < 10; i++) begin
      rnd_fill();
      drive(1, (i % 2) == 0, (i % 2) == 0);
    end
    // Gapped random traffic
    for (int i = 0; i < 250; i++) begin
      rnd_fill();
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end
    idle(5);

    // Long group to pin counter saturation
    for (int i = 0; i < 300; i++) begin
      rnd_fill();
      drive(1, 1, i == 299);
    end
    idle(4);
    @(negedge clk);
    check("long count", int'(if_s.out_count), CMAX);
    check("long valid", int'(if_s.out_valid), 1);

    // Reset in the middle of an open group
    rnd_fill();
    drive(1, 1, 0);
    drive(1, 1, 0);
    @(posedge clk);
    #1;
    apply(0, 0, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid reset valid", int'(if_s.out_valid), 0);
    check("mid reset data", int'(if_s.out_data), 0);
    check("mid reset count", int'(if_s.out_count), 0);
    check("mid reset flag", int'(if_s.out_sat), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    fill(0);
    lb[0] = 5;
    drive(1, 1, 1);
    idle(4);
    @(negedge clk);
    lit("post reset", 5, 1, 0);
    idle(4);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
